// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: sizing, instruction class codes,
// the per-entry record and the operand lookup/bypass helper.
package rob_pkg;

   localparam int ROB_WIDTH     = 8;
   localparam int ROB_WIDTH_BIT = 3;
   localparam int REG_ID_BIT    = 5;
   localparam int CNT_W         = ROB_WIDTH_BIT + 1;

   typedef enum logic [1:0] {
      ROB_ALU  = 2'd0,
      ROB_BR   = 2'd1,
      ROB_JALR = 2'd2
   } rob_type_e;

   typedef struct packed {
      logic                  busy;
      logic                  ready;
      rob_type_e             typ;
      logic [REG_ID_BIT-1:0] rd;
      logic                  pred;
      logic [31:0]           alt_pc;
      logic [31:0]           value;
      logic [31:0]           pc;
   } rob_entry_t;

   // Code 3 is unused by the decoder and behaves like a plain ALU op.
   function automatic rob_type_e decode_type(input logic [1:0] raw);
      case (raw)
         2'd1:    return ROB_BR;
         2'd2:    return ROB_JALR;
         default: return ROB_ALU;
      endcase
   endfunction

   // Returns {ready, value}; a result on the bus this cycle wins over storage.
   function automatic logic [32:0] query(input logic        st_ready,
                                         input logic [31:0] st_value,
                                         input logic        hit,
                                         input logic [31:0] hit_value);
      if (hit) return {1'b1, hit_value};
      return {st_ready, st_value};
   endfunction

endpackage

// File: rtl/rob.sv
// Reorder buffer. Allocates entries in program order from the decoder,
// accepts out-of-order results from the reservation stations, retires one
// entry per cycle to the register file and flushes on branch mispredict or
// jalr commit.
// Ports:
//   clk_in, rst_in (async, active high), rdy_in (stall when low)
//   issue_*  : allocation request, issue_tag returns the tail tag
//   res_*    : result write-back from the reservation stations
//   qj/qk_*  : operand lookup with same-cycle result bypass
//   commit_* : registered retirement pulse toward the register file
//   flush_*  : registered pipeline redirect pulse
module rob
   import rob_pkg::*;
(
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   output logic                     rob_full,
   input  logic                     issue_valid,
   input  logic [1:0]               issue_type,
   input  logic [REG_ID_BIT-1:0]    issue_rd,
   input  logic                     issue_pred_taken,
   input  logic [31:0]              issue_alt_pc,
   output logic [ROB_WIDTH_BIT-1:0] issue_tag,
   input  logic                     res_valid,
   input  logic [ROB_WIDTH_BIT-1:0] res_tag,
   input  logic [31:0]              res_value,
   input  logic [31:0]              res_pc,
   input  logic [ROB_WIDTH_BIT-1:0] qj_tag,
   input  logic [ROB_WIDTH_BIT-1:0] qk_tag,
   output logic                     qj_ready,
   output logic                     qk_ready,
   output logic [31:0]              qj_value,
   output logic [31:0]              qk_value,
   output logic                     commit_valid,
   output logic [REG_ID_BIT-1:0]    commit_rd,
   output logic [31:0]              commit_value,
   output logic [ROB_WIDTH_BIT-1:0] commit_tag,
   output logic                     flush_out,
   output logic [31:0]              flush_pc
);

   rob_entry_t                entries_q [ROB_WIDTH];
   rob_entry_t                entries_d [ROB_WIDTH];
   logic [ROB_WIDTH_BIT-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic                      commit_valid_q, commit_valid_d;
   logic [REG_ID_BIT-1:0]     commit_rd_q, commit_rd_d;
   logic [31:0]               commit_value_q, commit_value_d;
   logic [ROB_WIDTH_BIT-1:0]  commit_tag_q, commit_tag_d;
   logic                      flush_q, flush_d;
   logic [31:0]               flush_pc_q, flush_pc_d;

   rob_entry_t                head_ent;
   logic                      do_commit, issue_acc;
   logic [32:0]               qj_res, qk_res;

   // Full is judged on the pre-edge count: a slot freed by this cycle's
   // commit is not reusable until the next cycle.
   assign rob_full  = (count_q == CNT_W'(ROB_WIDTH));
   assign issue_tag = tail_q;
   assign issue_acc = rdy_in && issue_valid && !rob_full;
   assign head_ent  = entries_q[head_q];
   assign do_commit = rdy_in && head_ent.busy && head_ent.ready;

   assign qj_res   = query(entries_q[qj_tag].ready, entries_q[qj_tag].value,
                           res_valid && (res_tag == qj_tag), res_value);
   assign qk_res   = query(entries_q[qk_tag].ready, entries_q[qk_tag].value,
                           res_valid && (res_tag == qk_tag), res_value);
   assign qj_ready = qj_res[32];
   assign qj_value = qj_res[31:0];
   assign qk_ready = qk_res[32];
   assign qk_value = qk_res[31:0];

   always_comb begin
      entries_d      = entries_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      commit_valid_d = 1'b0;
      commit_rd_d    = commit_rd_q;
      commit_value_d = commit_value_q;
      commit_tag_d   = commit_tag_q;
      flush_d        = 1'b0;
      flush_pc_d     = flush_pc_q;

      if (do_commit) begin
         case (head_ent.typ)
            ROB_BR: begin
               if (head_ent.value[0] != head_ent.pred) begin
                  flush_d    = 1'b1;
                  flush_pc_d = head_ent.alt_pc;
               end
            end
            default: begin
               commit_valid_d = 1'b1;
               commit_rd_d    = head_ent.rd;
               commit_value_d = head_ent.value;
               commit_tag_d   = head_q;
               if (head_ent.typ == ROB_JALR) begin
                  flush_d    = 1'b1;
                  flush_pc_d = head_ent.pc;
               end
            end
         endcase
      end

      if (rdy_in) begin
         if (flush_d) begin
            // Redirect: drop everything younger, including this edge's issue/result.
            for (int i = 0; i < ROB_WIDTH; i++) entries_d[i] = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end else begin
            if (res_valid && entries_q[res_tag].busy) begin
               entries_d[res_tag].ready = 1'b1;
               entries_d[res_tag].value = res_value;
               entries_d[res_tag].pc    = res_pc;
            end
            if (do_commit) begin
               entries_d[head_q].busy  = 1'b0;
               entries_d[head_q].ready = 1'b0;
               head_d = head_q + ROB_WIDTH_BIT'(1);
            end
            if (issue_acc) begin
               entries_d[tail_q].busy   = 1'b1;
               entries_d[tail_q].ready  = 1'b0;
               entries_d[tail_q].typ    = decode_type(issue_type);
               entries_d[tail_q].rd     = issue_rd;
               entries_d[tail_q].pred   = issue_pred_taken;
               entries_d[tail_q].alt_pc = issue_alt_pc;
               tail_d = tail_q + ROB_WIDTH_BIT'(1);
            end
            case ({issue_acc, do_commit})
               2'b10:   count_d = count_q + CNT_W'(1);
               2'b01:   count_d = count_q - CNT_W'(1);
               default: count_d = count_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < ROB_WIDTH; i++) entries_q[i] <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_rd_q    <= '0;
         commit_value_q <= '0;
         commit_tag_q   <= '0;
         flush_q        <= 1'b0;
         flush_pc_q     <= '0;
      end else begin
         entries_q      <= entries_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         commit_valid_q <= commit_valid_d;
         commit_rd_q    <= commit_rd_d;
         commit_value_q <= commit_value_d;
         commit_tag_q   <= commit_tag_d;
         flush_q        <= flush_d;
         flush_pc_q     <= flush_pc_d;
      end
   end

   assign commit_valid = commit_valid_q;
   assign commit_rd    = commit_rd_q;
   assign commit_value = commit_value_q;
   assign commit_tag   = commit_tag_q;
   assign flush_out    = flush_q;
   assign flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_rob.sv
module tb_rob;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        rob_full;
   logic        issue_valid;
   logic [1:0]  issue_type;
   logic [4:0]  issue_rd;
   logic        issue_pred_taken;
   logic [31:0] issue_alt_pc;
   logic [2:0]  issue_tag;
   logic        res_valid;
   logic [2:0]  res_tag;
   logic [31:0] res_value, res_pc;
   logic [2:0]  qj_tag, qk_tag;
   logic        qj_ready, qk_ready;
   logic [31:0] qj_value, qk_value;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [31:0] commit_value;
   logic [2:0]  commit_tag;
   logic        flush_out;
   logic [31:0] flush_pc;

   always #5 clk_in = ~clk_in;

   rob dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_full(rob_full),
      .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
      .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
      .issue_tag(issue_tag), .res_valid(res_valid), .res_tag(res_tag),
      .res_value(res_value), .res_pc(res_pc), .qj_tag(qj_tag), .qk_tag(qk_tag),
      .qj_ready(qj_ready), .qk_ready(qk_ready), .qj_value(qj_value),
      .qk_value(qk_value), .commit_valid(commit_valid), .commit_rd(commit_rd),
      .commit_value(commit_value), .commit_tag(commit_tag),
      .flush_out(flush_out), .flush_pc(flush_pc)
   );

   // Reference model: in-flight instructions in program order.
   typedef struct {
      logic [2:0]  tag;
      logic [1:0]  typ;
      logic [4:0]  rd;
      logic        pred;
      logic [31:0] alt;
      logic [31:0] value;
      logic [31:0] pc;
      bit          ready;
   } ment_t;

   ment_t       mq[$];
   int          m_tail;
   logic        e_cv, e_fl;
   logic [31:0] e_rd, e_val, e_tag, e_fpc;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   function automatic int find(input logic [2:0] t);
      foreach (mq[i]) if (mq[i].tag == t) return i;
      return -1;
   endfunction

   task automatic check_q(input string name, input logic [2:0] t,
                          input logic rdy, input logic [31:0] val);
      int idx;
      idx = find(t);
      if (res_valid && res_tag == t) begin
         chk({name, "_rdy_byp"}, rdy, 1'b1);
         chk({name, "_val_byp"}, val, res_value);
      end else if (idx >= 0) begin
         chk({name, "_rdy"}, rdy, mq[idx].ready);
         if (mq[idx].ready) chk({name, "_val"}, val, mq[idx].value);
      end
   endtask

   task automatic model_edge();
      bit    commit, flush, full;
      ment_t h;
      int    idx;
      e_cv = 1'b0;
      e_fl = 1'b0;
      if (!rdy_in) return;
      commit = (mq.size() > 0) && mq[0].ready;
      flush  = 1'b0;
      if (commit) begin
         h = mq[0];
         if (h.typ == 2'd1) begin
            if (h.value[0] != h.pred) begin
               flush = 1'b1;
               e_fpc = h.alt;
            end
         end else begin
            e_cv  = 1'b1;
            e_rd  = 32'(h.rd);
            e_val = h.value;
            e_tag = 32'(h.tag);
            if (h.typ == 2'd2) begin
               flush = 1'b1;
               e_fpc = h.pc;
            end
         end
      end
      if (flush) begin
         e_fl = 1'b1;
         mq.delete();
         m_tail = 0;
         return;
      end
      full = (mq.size() == 8);
      if (res_valid) begin
         idx = find(res_tag);
         if (idx >= 0) begin
            mq[idx].ready = 1'b1;
            mq[idx].value = res_value;
            mq[idx].pc    = res_pc;
         end
      end
      if (commit) void'(mq.pop_front());
      if (issue_valid && !full) begin
         mq.push_back('{tag: 3'(m_tail), typ: issue_type, rd: issue_rd,
                        pred: issue_pred_taken, alt: issue_alt_pc,
                        value: 32'h0, pc: 32'h0, ready: 1'b0});
         m_tail = (m_tail + 1) % 8;
      end
   endtask

   task automatic cycle();
      @(negedge clk_in);
      chk("rob_full", rob_full, (mq.size() == 8));
      chk("issue_tag", issue_tag, 32'(m_tail));
      check_q("qj", qj_tag, qj_ready, qj_value);
      check_q("qk", qk_tag, qk_ready, qk_value);
      @(posedge clk_in);
      model_edge();
      #1;
      chk("commit_valid", commit_valid, e_cv);
      chk("flush_out", flush_out, e_fl);
      if (e_cv) begin
         chk("commit_rd", commit_rd, e_rd);
         chk("commit_value", commit_value, e_val);
         chk("commit_tag", commit_tag, e_tag);
      end
      if (e_fl) chk("flush_pc", flush_pc, e_fpc);
   endtask

   task automatic idle();
      rdy_in = 1'b1; issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0;
      issue_pred_taken = 1'b0; issue_alt_pc = 32'h0; res_valid = 1'b0;
      res_tag = 3'd0; res_value = 32'h0; res_pc = 32'h0; qj_tag = 3'd0; qk_tag = 3'd0;
   endtask

   task automatic issue(input logic [1:0] t, input logic [4:0] rd,
                        input logic pred, input logic [31:0] alt);
      idle();
      issue_valid = 1'b1; issue_type = t; issue_rd = rd;
      issue_pred_taken = pred; issue_alt_pc = alt;
   endtask

   task automatic result(input logic [2:0] t, input logic [31:0] v, input logic [31:0] pc);
      idle();
      res_valid = 1'b1; res_tag = t; res_value = v; res_pc = pc;
   endtask

   // Asserted between clock edges: outputs must clear without waiting for a clock.
   task automatic do_reset();
      rst_in = 1'b1;
      #1;
      chk("rst_commit_valid", commit_valid, 1'b0);
      chk("rst_flush_out", flush_out, 1'b0);
      chk("rst_commit_rd", commit_rd, 5'd0);
      chk("rst_commit_value", commit_value, 32'h0);
      chk("rst_commit_tag", commit_tag, 3'd0);
      chk("rst_flush_pc", flush_pc, 32'h0);
      chk("rst_rob_full", rob_full, 1'b0);
      chk("rst_issue_tag", issue_tag, 3'd0);
      mq.delete();
      m_tail = 0;
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
   endtask

   initial begin
      logic [2:0] pend[$];
      int r;
      rst_in = 1'b0;
      m_tail = 0;
      e_cv = 1'b0; e_fl = 1'b0;
      e_rd = '0; e_val = '0; e_tag = '0; e_fpc = '0;
      idle();
      #1;
      do_reset();

      // 1: single ALU op round trip
      issue(2'd0, 5'd5, 1'b0, 32'h0);         cycle();
      result(3'd0, 32'h1234, 32'h0);          cycle();
      idle();                                 cycle();
      chk("t1_cv", commit_valid, 1'b1);
      chk("t1_rd", commit_rd, 5'd5);
      chk("t1_val", commit_value, 32'h1234);
      chk("t1_tag", commit_tag, 3'd0);

      // 2: out-of-order results retire in order
      do_reset();
      for (int i = 0; i < 3; i++) begin issue(2'd0, 5'(i + 1), 1'b0, 32'h0); cycle(); end
      result(3'd2, 32'h22, 32'h0); cycle();
      result(3'd0, 32'h20, 32'h0); cycle();
      result(3'd1, 32'h21, 32'h0); cycle();
      chk("t2_tag0", commit_tag, 3'd0);
      idle(); cycle();
      chk("t2_tag1", commit_tag, 3'd1);
      cycle();
      chk("t2_tag2", commit_tag, 3'd2);

      // 3: full, dropped issue, no reuse of a slot freed on the same edge
      do_reset();
      for (int i = 0; i < 9; i++) begin issue(2'd0, 5'(i), 1'b0, 32'h0); cycle(); end
      chk("t3_full", rob_full, 1'b1);
      issue(2'd0, 5'd9, 1'b0, 32'h0);
      res_valid = 1'b1; res_tag = 3'd0; res_value = 32'h77;
      cycle();
      res_valid = 1'b0;
      cycle();
      chk("t3_cv", commit_valid, 1'b1);
      chk("t3_notfull", rob_full, 1'b0);
      chk("t3_wrap_tag", issue_tag, 3'd0);
      cycle();
      chk("t3_refull", rob_full, 1'b1);

      // 4: branch mispredict, then correct prediction
      do_reset();
      issue(2'd1, 5'd0, 1'b1, 32'h100); cycle();
      result(3'd0, 32'h0, 32'h0);       cycle();
      idle();                           cycle();
      chk("t4_flush", flush_out, 1'b1);
      chk("t4_fpc", flush_pc, 32'h100);
      chk("t4_cv", commit_valid, 1'b0);
      issue(2'd1, 5'd0, 1'b1, 32'h200); cycle();
      result(3'd0, 32'h1, 32'h0);       cycle();
      idle();                           cycle();
      chk("t4_noflush", flush_out, 1'b0);

      // 5: jalr commit with younger entries
      do_reset();
      issue(2'd2, 5'd1, 1'b0, 32'h0); cycle();
      issue(2'd0, 5'd2, 1'b0, 32'h0); cycle();
      issue(2'd0, 5'd3, 1'b0, 32'h0); cycle();
      result(3'd0, 32'h44, 32'h2000); cycle();
      idle();                         cycle();
      chk("t5_cv", commit_valid, 1'b1);
      chk("t5_rd", commit_rd, 5'd1);
      chk("t5_val", commit_value, 32'h44);
      chk("t5_flush", flush_out, 1'b1);
      chk("t5_fpc", flush_pc, 32'h2000);
      chk("t5_tail", issue_tag, 3'd0);

      // 6: same-cycle bypass, then reset while a commit pulse is showing
      do_reset();
      for (int i = 0; i < 4; i++) begin issue(2'd0, 5'(i), 1'b0, 32'h0); cycle(); end
      result(3'd3, 32'hAB, 32'h0);
      qj_tag = 3'd3;
      #1;
      chk("t6_qj_ready", qj_ready, 1'b1);
      chk("t6_qj_value", qj_value, 32'hAB);
      cycle();
      result(3'd0, 32'h5, 32'h0); cycle();
      idle();                     cycle();
      chk("t6_pre_rst_cv", commit_valid, 1'b1);
      do_reset();

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         idle();
         rdy_in = ($urandom_range(9) != 0);
         issue_valid = ($urandom_range(2) != 0);
         r = $urandom_range(9);
         issue_type = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
         issue_rd = 5'($urandom);
         issue_pred_taken = 1'($urandom);
         issue_alt_pc = $urandom;
         pend.delete();
         foreach (mq[i]) if (!mq[i].ready) pend.push_back(mq[i].tag);
         res_valid = ($urandom_range(3) != 0);
         if (pend.size() > 0 && $urandom_range(4) != 0)
            res_tag = pend[$urandom_range(pend.size() - 1)];
         else
            res_tag = 3'($urandom);
         res_value = $urandom;
         res_pc = $urandom;
         if (mq.size() > 0 && $urandom_range(3) != 0) qj_tag = mq[$urandom_range(mq.size() - 1)].tag;
         else qj_tag = 3'($urandom);
         if (mq.size() > 0 && $urandom_range(3) != 0) qk_tag = mq[$urandom_range(mq.size() - 1)].tag;
         else qk_tag = 3'($urandom);
         cycle();
         if (n % 700 == 699) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rob.md
Name: rob

Overview:
Reorder buffer for the Tomasulo RISC-V core; it is the consumer end of the RS result interface.
- Allocates one entry per instruction issued by the Decoder.
- Accepts out-of-order results from the RS (value, tag, jalr target).
- Retires entries in program order to the register file.
- Flushes the pipeline when a branch was mispredicted or a jalr commits.

Parameters:
ROB_WIDTH, 8, number of entries (power of two)
ROB_WIDTH_BIT, 3, log2(ROB_WIDTH); width of every tag
REG_ID_BIT, 5, architectural register index width

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  asynchronous active-high reset
rdy_in  in  1  pause when low
rob_full  out  1  count == ROB_WIDTH (registered count, combinational compare)
issue_valid  in  1  Decoder allocates an entry this cycle
issue_type  in  2  0 ALU/LUI/AUIPC/JAL, 1 BRANCH, 2 JALR, 3 treated as ALU
issue_rd  in  REG_ID_BIT  destination register
issue_pred_taken  in  1  branch prediction made at decode
issue_alt_pc  in  32  redirect PC if branch mispredicted
issue_tag  out  ROB_WIDTH_BIT  tag to be assigned = tail (combinational)
res_valid  in  1  RS has_result
res_tag  in  ROB_WIDTH_BIT  entry being completed
res_value  in  32  RS value
res_pc  in  32  RS new_PC (jalr target)
qj_tag, qk_tag  in  ROB_WIDTH_BIT  operand lookups from Decoder
qj_ready, qk_ready  out  1  entry value available (combinational)
qj_value, qk_value  out  32  entry value, forwarded
commit_valid  out  1  registered one-cycle pulse, register write
commit_rd  out  REG_ID_BIT  committed destination
commit_value  out  32  committed value
commit_tag  out  ROB_WIDTH_BIT  tag retired, so the regfile clears its dependency
flush_out  out  1  registered one-cycle pulse, pipeline flush
flush_pc  out  32  fetch restart PC

Behaviour:
- State per entry: busy, ready, type, rd, pred, alt_pc, value, pc. Globals: head, tail, count (ROB_WIDTH_BIT+1 bits).
- Reset (async, any time, including mid-flush): head=tail=count=0, all busy/ready=0. Outputs: commit_valid=0, flush_out=0, commit_rd=0, commit_value=0, commit_tag=0, flush_pc=0.
- rdy_in low: all state holds; commit_valid and flush_out are driven 0 at that edge.
- Issue: if issue_valid && !rob_full, entry[tail] is loaded with busy=1, ready=0; tail wraps modulo ROB_WIDTH; count+1. Issue while full is dropped silently.
- Result: if res_valid && entry[res_tag].busy, set ready=1 and latch value and pc. Result to a non-busy entry is ignored.
- Commit: at most one per cycle, only when entry[head].busy && ready.
  - head advances, count-1, busy cleared.
  - commit_valid=1 for ALU and JALR, with rd/value/tag; for BRANCH commit_valid=0.
  - BRANCH: if value[0] != pred, then flush_out=1 and flush_pc=alt_pc.
  - JALR: always flush_out=1, flush_pc=pc.
- Flush cycle: all entries cleared, head=tail=count=0. Same-edge issue and result are discarded. commit_valid for the JALR link value is still asserted.
- Simultaneous issue and commit (no flush): count unchanged. rob_full uses the pre-edge count, so no issue is accepted while full even if a commit frees a slot that cycle.
- Latency: a result arriving at edge N to head commits at edge N+1 (pulse visible after N+1).
- Query: qX_ready = entry[qX_tag].ready || (res_valid && res_tag==qX_tag). qX_value takes res_value on a bypass hit, otherwise the stored value.

Decomposition:
- const.v holds ROB_WIDTH, ROB_WIDTH_BIT, REG_ID_BIT and the issue_type codes (ROB_ALU=0, ROB_BR=1, ROB_JALR=2).
- No sub-module is needed; the query/bypass mux is one function duplicated for qj and qk.

Test Plan:
1. Reset, issue ALU rd=5 (tag 0), result tag0 value 0x1234 -> next edge commit_valid=1, rd=5, value=0x1234, tag=0; count=0.
2. Issue tags 0,1,2; results in order 2,0,1 -> commits strictly tag 0,1,2 on consecutive cycles after tag1's result.
3. Issue 8 entries -> rob_full=1; 9th issue dropped; commit head while issue_valid=1 -> no allocation that cycle, allocation accepted next cycle at tag 0 (wrap).
4. BRANCH pred=1, alt_pc=0x100, result value=0 -> flush_out=1, flush_pc=0x100, commit_valid=0, count=0. Repeat with value=1 -> no flush.
5. JALR rd=1, result value=0x44, pc=0x2000 with two younger entries -> commit rd=1 value=0x44 and flush_pc=0x2000 on the same edge; younger entries gone.
6. qj_tag=3 with res_valid on tag 3, value 0xAB -> qj_ready=1 and qj_value=0xAB in the same cycle. Separately, assert rst_in mid-operation -> all outputs 0 immediately.
